// File: rtl/lane_scan_controller.sv
// Scan sequencer for the 3-to-8 lane decoder: steps through enabled lanes
// with blanking and dwell, and swaps double-buffered frames at each scan wrap.
module lane_scan_controller #(
    parameter int         ROW_W        = 8,
    parameter int         DWELL_CYCLES = 1000,
    parameter int         BLANK_CYCLES = 4,
    parameter logic [7:0] LANE_ENABLE  = 8'h1F
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         lane_mask,
    input  logic [8*ROW_W-1:0] frame_data,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [2:0]         sel,
    output logic               blank,
    output logic [ROW_W-1:0]   row_data,
    output logic               frame_start
);

    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2:0]         sel_n;
    logic               blank_n, fs_n;
    logic [ROW_W-1:0]   row_n;
    logic [8*ROW_W-1:0] active, active_n, pending;
    logic               pfull, pfull_n, xfer, swap;
    logic [7:0]         eff;
    logic [2:0]         low;
    logic [3:0]         above;

    assign eff  = lane_mask & LANE_ENABLE;
    assign xfer = frame_valid & frame_ready;
    assign swap = frame_start & pfull;

    always_comb begin
        low = '0;
        for (int i = 7; i >= 0; i--)
            if (eff[i]) low = 3'(i);
    end

    // {found, index} of the lowest enabled lane above sel
    always_comb begin
        above = '0;
        for (int i = 7; i >= 0; i--)
            if (eff[i] && (3'(i) > sel)) above = {1'b1, 3'(i)};
    end

    // Swap happens while frame_start is high, so it never races a transfer
    always_comb begin
        active_n = swap ? pending : active;
        pfull_n  = pfull;
        if (xfer)
            pfull_n = 1'b1;
        else if (swap)
            pfull_n = 1'b0;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        blank_n = 1'b1;
        fs_n    = 1'b0;
        row_n   = '0;
        unique case (state)
            IDLE: begin
                sel_n = '0;
                if (enable && (eff != 8'h00)) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    sel_n   = low;
                    fs_n    = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sel_n   = '0;
                end else if (cnt == BLAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                    blank_n = 1'b0;
                    row_n   = active_n[int'(sel)*ROW_W +: ROW_W];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sel_n   = '0;
                end else if (cnt == DLAST) begin
                    cnt_n = '0;
                    if (eff == 8'h00) begin
                        state_n = IDLE;
                        sel_n   = '0;
                    end else if (above[3]) begin
                        state_n = BLANK;
                        sel_n   = above[2:0];
                    end else begin
                        state_n = BLANK;
                        sel_n   = low;
                        fs_n    = 1'b1;
                    end
                end else begin
                    cnt_n   = cnt + CW'(1);
                    blank_n = 1'b0;
                    row_n   = active_n[int'(sel)*ROW_W +: ROW_W];
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sel_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel         <= '0;
            blank       <= 1'b1;
            row_data    <= '0;
            frame_start <= 1'b0;
            frame_ready <= 1'b1;
            active      <= '0;
            pending     <= '0;
            pfull       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            blank       <= blank_n;
            row_data    <= row_n;
            frame_start <= fs_n;
            frame_ready <= !pfull_n;
            active      <= active_n;
            pfull       <= pfull_n;
            if (xfer)
                pending <= frame_data;
        end
    end

endmodule

// File: tb/tb_lane_scan_controller.sv
// Scoreboard bench for lane_scan_controller with a short dwell and blank.
module tb_lane_scan_controller;

    localparam int BLK = 2;
    localparam int DWL = 3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  lane_mask;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  sel;
    logic        blank;
    logic [7:0]  row_data;
    logic        frame_start;

    int          n_cmp;
    int          n_err;
    logic [12:0] sbq[$];

    localparam logic [63:0] F1 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] FA = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] FB = 64'h0000_0000_0000_B03C;
    localparam logic [63:0] FC = 64'h0000_00C4_C3C2_C15A;
    localparam logic [63:0] FD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] F0 = 64'h0;

    lane_scan_controller #(
        .ROW_W(8), .DWELL_CYCLES(DWL), .BLANK_CYCLES(BLK), .LANE_ENABLE(8'h1F)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .lane_mask(lane_mask),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .sel(sel), .blank(blank),
        .row_data(row_data), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] tup(logic [2:0] s, logic b, logic f, logic [7:0] r);
        return {s, b, f, r};
    endfunction

    // One lane period: BLK blanked cycles, then DWL cycles of that lane's row
    task automatic exp_lane(int lane, bit first, logic [63:0] fr, int n);
        for (int i = 0; i < BLK + DWL && i < n; i++) begin
            if (i < BLK)
                sbq.push_back(tup(3'(lane), 1'b1, first && (i == 0), 8'h00));
            else
                sbq.push_back(tup(3'(lane), 1'b0, 1'b0, fr[lane*8 +: 8]));
        end
    endtask

    task automatic exp_idle(int n);
        repeat (n) sbq.push_back(tup(3'd0, 1'b1, 1'b0, 8'h00));
    endtask

    task automatic run(int n);
        logic [12:0] e;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (sbq.size() == 0) begin
                check("scan_nodata", 32'({sel, blank, frame_start, row_data}), 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                check("scan", 32'({sel, blank, frame_start, row_data}), 32'(e));
            end
        end
    endtask

    task automatic restart(logic [7:0] m);
        enable = 1'b0;
        exp_idle(1);
        run(1);
        lane_mask = m;
        enable = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        enable = 1'b0;
        lane_mask = 8'hFF;
        frame_data = '0;
        frame_valid = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_row", 32'(row_data), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_ready", 32'(frame_ready), 32'd1);

        // load a frame while idle
        @(negedge clk);
        reset = 1'b0;
        frame_valid = 1'b1;
        frame_data = F1;
        @(posedge clk);
        @(negedge clk);
        frame_valid = 1'b0;
        check("idle_xfer_ready", 32'(frame_ready), 32'd0);
        check("idle_blank", 32'(blank), 32'd1);

        // basic scan over lanes 0..4, then lane skip with a mid-lane mask change
        enable = 1'b1;
        exp_lane(0, 1, F1, 5);
        exp_lane(1, 0, F1, 5);
        exp_lane(2, 0, F1, 5);
        exp_lane(3, 0, F1, 5);
        exp_lane(4, 0, F1, 5);
        exp_lane(0, 1, F1, 5);
        run(30);
        lane_mask = 8'h15;
        exp_lane(2, 0, F1, 5);
        exp_lane(4, 0, F1, 5);
        exp_lane(0, 1, F1, 5);
        exp_lane(2, 0, F1, 5);
        run(18);
        lane_mask = 8'h02;
        run(2);
        exp_lane(1, 1, F1, 5);
        exp_lane(1, 1, F1, 5);
        exp_lane(1, 1, F1, 5);
        run(15);

        // handshake: A accepted, B held off until after the next wrap
        restart(8'h01);
        exp_lane(0, 1, F1, 5);
        exp_lane(0, 1, FA, 5);
        exp_lane(0, 1, FB, 5);
        exp_lane(0, 1, FB, 5);
        exp_lane(0, 1, FC, 5);
        run(3);
        frame_valid = 1'b1;
        frame_data = FA;
        run(1);
        check("hs_busy_a", 32'(frame_ready), 32'd0);
        frame_data = FB;
        run(1);
        check("hs_hold_b1", 32'(frame_ready), 32'd0);
        run(1);
        check("hs_hold_fs", 32'(frame_ready), 32'd0);
        run(1);
        check("hs_ready_after_swap", 32'(frame_ready), 32'd1);
        run(1);
        check("hs_busy_b", 32'(frame_ready), 32'd0);
        frame_valid = 1'b0;
        run(8);

        // transfer in the same cycle as frame_start with pending empty
        check("sim_fs", 32'(frame_start), 32'd1);
        check("sim_ready", 32'(frame_ready), 32'd1);
        frame_valid = 1'b1;
        frame_data = FC;
        run(1);
        check("sim_taken", 32'(frame_ready), 32'd0);
        frame_valid = 1'b0;
        run(8);

        // enable drop during lane 3 show, then re-enable
        restart(8'hFF);
        exp_lane(0, 1, FC, 5);
        exp_lane(1, 0, FC, 5);
        exp_lane(2, 0, FC, 5);
        exp_lane(3, 0, FC, 3);
        run(18);
        enable = 1'b0;
        exp_idle(3);
        run(3);
        enable = 1'b1;
        exp_lane(0, 1, FC, 5);
        exp_lane(1, 0, FC, 5);
        run(10);

        // async reset mid-show with a pending frame
        exp_lane(2, 0, FC, 3);
        frame_valid = 1'b1;
        frame_data = FD;
        run(3);
        frame_valid = 1'b0;
        check("pre_rst_ready", 32'(frame_ready), 32'd0);
        check("pre_rst_row", 32'(row_data), 32'hC2);
        #2 reset = 1'b1;
        #1;
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_blank", 32'(blank), 32'd1);
        check("arst_row", 32'(row_data), 32'd0);
        check("arst_ready", 32'(frame_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        exp_lane(0, 1, F0, 5);
        exp_lane(1, 0, F0, 5);
        run(10);

        // empty mask: advance drops to idle and stays there
        lane_mask = 8'h00;
        exp_idle(8);
        run(8);

        check("sb_left", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
